// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// instr_encoder_pkg
// Shared RV32I opcode definitions, widths, NOP word, error codes and format
// classes used by the instruction encoder.
// Revision: 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    localparam int WIDTH = 32;

    // Base RV32I opcodes
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_J     = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // addi x0,x0,0 - emitted in place of any rejected bundle
    localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_ALIGN  = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHIFT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_J     = 3'd5,
        FMT_BAD   = 3'd6
    } fmt_e;

    // True when imm equals the sign-extension of its low 'bits' bits
    function automatic logic imm_fits(input logic [WIDTH-1:0] imm, input int unsigned bits);
        logic [WIDTH-1:0] ext;
        ext = imm << (WIDTH - bits);
        ext = $unsigned($signed(ext) >>> (WIDTH - bits));
        return ext == imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// instr_pack
// Combinational packer: turns a classified field bundle into a 32-bit RV32I
// instruction word.
// Revision: 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fmt_e             fmt_i,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] instr_o
);

    // Upper immediate bits are only range-checked, never packed
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[WIDTH-1:21];

    // Field placement per instruction format
    always_comb begin
        instr_o = NOP_INSTR;
        case (fmt_i)
            FMT_R:     instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I:     instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_SHIFT: instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S:     instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B:     instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                  imm_i[4:1], imm_i[11], opcode_i};
            FMT_J:     instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                  rd_i, opcode_i};
            default:   instr_o = NOP_INSTR;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder
// Two-stage elastic RV32I encoder: S1 validates and classifies a field
// bundle, S2 holds the packed word with its sequential byte address.
// Revision: 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [WIDTH-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_err,
    output logic [1:0]       out_err_code,
    output logic [15:0]      err_count
);

    // S1 registers
    logic             s1_valid_q;
    logic [6:0]       s1_opcode_q;
    logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]       s1_funct3_q;
    logic [6:0]       s1_funct7_q;
    logic [WIDTH-1:0] s1_imm_q;
    fmt_e             s1_fmt_q;
    err_code_e        s1_err_q;

    // S2 / output registers
    logic             out_valid_q;
    logic [WIDTH-1:0] out_instr_q;
    logic             out_err_q;
    err_code_e        out_err_code_q;
    logic [WIDTH-1:0] addr_q;
    logic [15:0]      err_count_q;

    fmt_e             fmt_d;
    err_code_e        err_d;
    logic [WIDTH-1:0] packed_word;
    logic             s2_load;
    logic             out_fire;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_fire = out_valid_q && out_ready;

    // Classify the incoming bundle; error priority opcode > range > alignment
    always_comb begin
        fmt_d = FMT_BAD;
        err_d = ERR_OPCODE;
        case (in_opcode)
            OPC_R: begin
                fmt_d = FMT_R;
                err_d = ERR_NONE;
            end
            OPC_I, OPC_LOAD, OPC_JALR: begin
                // Shift-immediates use funct7 in the top bits and a 5-bit shamt
                if (in_opcode == OPC_I && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
                    fmt_d = FMT_SHIFT;
                    err_d = (in_imm[WIDTH-1:5] == '0) ? ERR_NONE : ERR_RANGE;
                end else begin
                    fmt_d = FMT_I;
                    err_d = imm_fits(in_imm, 12) ? ERR_NONE : ERR_RANGE;
                end
            end
            OPC_S: begin
                fmt_d = FMT_S;
                err_d = imm_fits(in_imm, 12) ? ERR_NONE : ERR_RANGE;
            end
            OPC_B: begin
                fmt_d = FMT_B;
                if (!imm_fits(in_imm, 13))  err_d = ERR_RANGE;
                else if (in_imm[0])         err_d = ERR_ALIGN;
                else                        err_d = ERR_NONE;
            end
            OPC_J: begin
                fmt_d = FMT_J;
                if (!imm_fits(in_imm, 21))  err_d = ERR_RANGE;
                else if (in_imm[0])         err_d = ERR_ALIGN;
                else                        err_d = ERR_NONE;
            end
            default: begin
                fmt_d = FMT_BAD;
                err_d = ERR_OPCODE;
            end
        endcase
    end

    // S1: capture the bundle and its classification whenever it can accept
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
            s1_fmt_q    <= FMT_BAD;
            s1_err_q    <= ERR_NONE;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_opcode_q <= in_opcode;
                s1_rd_q     <= in_rd;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_funct3_q <= in_funct3;
                s1_funct7_q <= in_funct7;
                s1_imm_q    <= in_imm;
                s1_fmt_q    <= fmt_d;
                s1_err_q    <= err_d;
            end
        end
    end

    instr_pack u_pack (
        .fmt_i    (s1_fmt_q),
        .opcode_i (s1_opcode_q),
        .rd_i     (s1_rd_q),
        .rs1_i    (s1_rs1_q),
        .rs2_i    (s1_rs2_q),
        .funct3_i (s1_funct3_q),
        .funct7_i (s1_funct7_q),
        .imm_i    (s1_imm_q),
        .instr_o  (packed_word)
    );

    // S2: load the packed word (NOP when rejected); hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_instr_q    <= NOP_INSTR;
            out_err_q      <= 1'b0;
            out_err_code_q <= ERR_NONE;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_instr_q    <= (s1_err_q == ERR_NONE) ? packed_word : NOP_INSTR;
                out_err_q      <= (s1_err_q != ERR_NONE);
                out_err_code_q <= s1_err_q;
            end
        end
    end

    // Address and saturating error counters advance on output handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= BASE_ADDR;
            err_count_q <= '0;
        end else if (out_fire) begin
            addr_q <= addr_q + WIDTH'(4);
            if (out_err_q && err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_addr     = addr_q;
    assign out_err      = out_err_q;
    assign out_err_code = out_err_code_q;
    assign err_count    = err_count_q;

endmodule
`default_nettype wire
